// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_1.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow_in,
    output logic o_d,
    output logic o_borrow_out
);

    assign o_d          = i_a ^ i_b ^ i_borrow_in;
    assign o_borrow_out = (~i_a & i_b) | (~i_a & i_borrow_in) | (i_b & i_borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B, LSB first, one bit per clock,
// with start/done handshake and borrow / zero / signed-overflow flags.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_diff,
    output logic         o_borrow,
    output logic         o_zero,
    output logic         o_overflow
);

    localparam int               CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     a_sr;
    logic [N-1:0]     b_sr;
    logic [N-1:0]     d_sr;
    logic             borrow_reg;
    logic [CNT_W-1:0] cnt;

    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;
    logic [N-1:0]     diff_final;
    logic             ovf_final;

    full_subtractor_1 u_cell (
        .i_a          (a_sr[0]),
        .i_b          (b_sr[0]),
        .i_borrow_in  (borrow_reg),
        .o_d          (cell_d),
        .o_borrow_out (cell_bout)
    );

    // New operands are taken from IDLE, or straight from DONE for back-to-back use.
    assign accept     = i_start && ((state == IDLE) || (state == DONE));
    assign last_bit   = (state == BUSY) && (cnt == LAST_BIT);
    assign diff_final = {cell_d, d_sr[N-1:1]};

    // On the last bit the cell sees the operand sign bits, so overflow needs no extra capture.
    assign ovf_final  = (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);

    assign o_busy = (state == BUSY);
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = i_start ? BUSY : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            o_diff     <= '0;
            o_borrow   <= 1'b0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_sr       <= i_a;
                b_sr       <= i_b;
                d_sr       <= '0;
                borrow_reg <= 1'b0;
                cnt        <= '0;
            end else if (state == BUSY) begin
                a_sr       <= a_sr >> 1;
                b_sr       <= b_sr >> 1;
                d_sr       <= diff_final;
                borrow_reg <= cell_bout;
                cnt        <= cnt + CNT_W'(1);
            end

            // Results are published only on the edge that enters DONE.
            if (last_bit) begin
                o_diff     <= diff_final;
                o_borrow   <= cell_bout;
                o_zero     <= (diff_final == '0);
                o_overflow <= ovf_final;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at N=8 and N=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, borrow8, zero8, ovf8;
    logic        busy16, done16, borrow16, zero16, ovf16;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    logic        sel16;
    logic        obs_busy, obs_done, obs_borrow, obs_zero, obs_ovf;
    logic [31:0] obs_diff;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_borrow(borrow8),
        .o_zero(zero8), .o_overflow(ovf8)
    );

    serial_subtractor #(.N(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(start16), .i_a(a16), .i_b(b16),
        .o_busy(busy16), .o_done(done16), .o_diff(diff16), .o_borrow(borrow16),
        .o_zero(zero16), .o_overflow(ovf16)
    );

    always_comb begin
        obs_busy   = busy8;
        obs_done   = done8;
        obs_diff   = 32'(diff8);
        obs_borrow = borrow8;
        obs_zero   = zero8;
        obs_ovf    = ovf8;
        if (sel16) begin
            obs_busy   = busy16;
            obs_done   = done16;
            obs_diff   = 32'(diff16);
            obs_borrow = borrow16;
            obs_zero   = zero16;
            obs_ovf    = ovf16;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation on the selected DUT; returns in the DONE cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int bcycles);
        if (sel16) begin
            start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
        end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
        bcycles = 0;
        while (obs_busy && bcycles < 64) begin
            bcycles++;
            tick();
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ed, input logic eb, input logic ez, input logic eo);
        int bc;
        do_op(a, b, bc);
        check({tag, "_busy_cycles"}, 32'(bc), sel16 ? 32'd16 : 32'd8);
        check({tag, "_done"},   32'(obs_done),   32'd1);
        check({tag, "_busy"},   32'(obs_busy),   32'd0);
        check({tag, "_diff"},   obs_diff,        ed);
        check({tag, "_borrow"}, 32'(obs_borrow), 32'(eb));
        check({tag, "_zero"},   32'(obs_zero),   32'(ez));
        check({tag, "_ovf"},    32'(obs_ovf),    32'(eo));
        tick();
        check({tag, "_done_fall"}, 32'(obs_done), 32'd0);
        check({tag, "_diff_hold"}, obs_diff,      ed);
    endtask

    // Reference via integer arithmetic, signed overflow from range test.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic bo, output logic z, output logic o);
        longint ua, ub, sa, sb, res, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) << w;
        d   = 32'((ua - ub + lim) % lim);
        bo  = (ua < ub);
        z   = (d == 32'd0);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        res = sa - sb;
        o   = (res >= lim / 2) || (res < -(lim / 2));
    endtask

    task automatic sweep(input int w);
        logic [31:0] a, b, ed, mask;
        logic eb, ez, eo;
        int bc;
        mask = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom() & mask;
            b = $urandom() & mask;
            if (i == 0) b = a;
            model(w, a, b, ed, eb, ez, eo);
            do_op(a, b, bc);
            check("sweep_done",   32'(obs_done),   32'd1);
            check("sweep_diff",   obs_diff,        ed);
            check("sweep_borrow", 32'(obs_borrow), 32'(eb));
            check("sweep_zero",   32'(obs_zero),   32'(ez));
            check("sweep_ovf",    32'(obs_ovf),    32'(eo));
        end
        tick();
    endtask

    initial begin
        int cyc;
        int done_seen;
        logic [7:0] b2b_a [3]  = '{8'h20, 8'h7F, 8'h01};
        logic [7:0] b2b_b [3]  = '{8'h08, 8'hFF, 8'h02};
        logic [7:0] b2b_d [3]  = '{8'h18, 8'h80, 8'hFF};
        logic       b2b_bo [3] = '{1'b0, 1'b1, 1'b1};
        logic       b2b_o [3]  = '{1'b0, 1'b1, 1'b0};

        sel16 = 1'b0;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",   32'(busy8),  32'd0);
        check("rst_done",   32'(done8),  32'd0);
        check("rst_diff",   32'(diff8),  32'd0);
        check("rst_borrow", 32'(borrow8), 32'd0);
        check("rst_zero",   32'(zero8),  32'd0);
        check("rst_ovf",    32'(ovf8),   32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_diff16", 32'(diff16), 32'd0);

        directed("d05_03", 32'h05, 32'h03, 32'h02, 1'b0, 1'b0, 1'b0);
        directed("d03_05", 32'h03, 32'h05, 32'hFE, 1'b1, 1'b0, 1'b0);
        directed("d80_01", 32'h80, 32'h01, 32'h7F, 1'b0, 1'b0, 1'b1);
        directed("dA5_A5", 32'hA5, 32'hA5, 32'h00, 1'b0, 1'b1, 1'b0);
        directed("d00_FF", 32'h00, 32'hFF, 32'h01, 1'b1, 1'b0, 1'b0);

        // Back-to-back: start held high, operands scrambled while busy.
        start8 = 1'b1; a8 = b2b_a[0]; b8 = b2b_b[0];
        tick();
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!done8 && cyc < 40) begin
                a8 = 8'($urandom());
                b8 = 8'($urandom());
                cyc++;
                tick();
            end
            check("b2b_period", 32'(cyc),     32'd8);
            check("b2b_busy",   32'(busy8),   32'd0);
            check("b2b_diff",   32'(diff8),   32'(b2b_d[k]));
            check("b2b_borrow", 32'(borrow8), 32'(b2b_bo[k]));
            check("b2b_ovf",    32'(ovf8),    32'(b2b_o[k]));
            if (k < 2) begin
                a8 = b2b_a[k + 1];
                b8 = b2b_b[k + 1];
            end else begin
                start8 = 1'b0;
            end
            tick();
            check("b2b_done_width", 32'(done8), 32'd0);
            check("b2b_restart",    32'(busy8), (k < 2) ? 32'd1 : 32'd0);
        end

        // Reset in the fourth busy cycle discards the operation.
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy4", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",   32'(busy8),   32'd0);
        check("mid_done",   32'(done8),   32'd0);
        check("mid_diff",   32'(diff8),   32'd0);
        check("mid_borrow", 32'(borrow8), 32'd0);
        check("mid_zero",   32'(zero8),   32'd0);
        check("mid_ovf",    32'(ovf8),    32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) done_seen++;
            tick();
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        directed("d10_01", 32'h10, 32'h01, 32'h0F, 1'b0, 1'b0, 1'b0);

        // Start together with reset is dropped.
        rst = 1'b1; start8 = 1'b1; a8 = 8'h44; b8 = 8'h22;
        tick();
        rst = 1'b0; start8 = 1'b0;
        check("rst_start_busy", 32'(busy8), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy8), 32'd0);
        check("rst_start_diff",  32'(diff8), 32'd0);

        // Start ignored while busy.
        start8 = 1'b1; a8 = 8'h09; b8 = 8'h04;
        tick();
        a8 = 8'hEE; b8 = 8'h11;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            cyc++;
            tick();
        end
        start8 = 1'b0;
        check("busy_start_period", 32'(cyc),   32'd8);
        check("busy_start_diff",   32'(diff8), 32'h05);
        tick();

        sweep(8);
        sel16 = 1'b1;
        directed("w16_0000_0001", 32'h0000, 32'h0001, 32'hFFFF, 1'b1, 1'b0, 1'b0);
        directed("w16_8000_0001", 32'h8000, 32'h0001, 32'h7FFF, 1'b0, 1'b0, 1'b1);
        sweep(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse arithmetic operation to the team's ripple adders. It computes D = A - B one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It is intended for area-constrained datapaths where a multi-cycle subtract is acceptable. It uses a start/done handshake and reports borrow, zero and signed-overflow flags.

Parameters:
N, 8, operand and result width in bits; legal range 2..32.

Ports:
i_clk  input  1  clock; all state updates occur on its rising edge.
i_reset  input  1  reset; synchronous, active-high.
i_start  input  1  request a new subtraction; sampled only when the block is accepting.
i_a  input  N  minuend (A); captured in the cycle i_start is accepted.
i_b  input  N  subtrahend (B); captured in the cycle i_start is accepted.
o_busy  output  1  high while bits are being processed (BUSY state).
o_done  output  1  one-cycle pulse; results are valid from this cycle on.
o_diff  output  N  A - B modulo 2^N.
o_borrow  output  1  1 iff A < B as unsigned numbers (final borrow out).
o_zero  output  1  1 iff o_diff == 0.
o_overflow  output  1  signed two's-complement overflow of A - B.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high and has priority over every other input.
- Reset values: state IDLE; o_busy=0, o_done=0, o_diff=0, o_borrow=0, o_zero=0, o_overflow=0; internal shift registers, borrow register and bit counter all cleared.
- States:
  - IDLE: o_busy=0. If i_start=1, capture i_a and i_b into shift registers, clear the borrow register, set counter=0, go to BUSY.
  - BUSY: o_busy=1. Each cycle:
    - cell inputs a=A_sr[0], b=B_sr[0], bin=borrow_reg.
    - d = a^b^bin; bout = (~a&b) | (~a&bin) | (b&bin).
    - d shifts into the result register from the MSB side; A_sr and B_sr shift right by one; borrow_reg <= bout; counter increments.
    - After the cycle that processes bit N-1 (counter==N-1), go to DONE.
  - DONE: o_done=1 for exactly this cycle, o_busy=0.
    - If i_start=1, accept new operands exactly as in IDLE and go to BUSY (back-to-back operation).
    - Otherwise go to IDLE.
- Output update: o_diff, o_borrow, o_zero and o_overflow update on the edge entering DONE. They hold stable until the next entry to DONE or until reset. They do not change during BUSY.
- Flag definitions: o_borrow = final bout. o_overflow = (A[N-1] != B[N-1]) && (D[N-1] != A[N-1]), using the captured operands. o_zero = (D == 0).
- Latency: start accepted at edge k -> BUSY during cycles k+1..k+N -> o_done high in cycle k+N+1. Throughput is one result per N+1 cycles.
- i_start during BUSY is ignored. i_a and i_b changes after capture have no effect.
- Reset mid-operation: on the next edge the block returns to IDLE with all outputs at reset values. The partial result is discarded and no o_done is generated.
- i_start asserted together with i_reset: reset wins and the request is dropped.

Decomposition:
- Package serial_subtractor_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t.
  - localparam CNT_W = $clog2(N) helper function.
- Sub-module full_subtractor_1: ports i_a, i_b, i_borrow_in, o_d, o_borrow_out. Purely combinational, implementing the d/bout equations above, and instantiated once.
- Top level contains the FSM, the bit counter, three N-bit shift registers, the borrow register and the flag logic.

Test Plan:
- N=8, A=0x05, B=0x03, start pulse -> o_busy high 8 cycles; o_done one cycle later; o_diff=0x02, o_borrow=0, o_zero=0, o_overflow=0.
- A=0x03, B=0x05 -> o_diff=0xFE, o_borrow=1, o_overflow=0; A=0x80, B=0x01 -> o_diff=0x7F, o_borrow=0, o_overflow=1.
- A=0xA5, B=0xA5 -> o_diff=0x00, o_zero=1, o_borrow=0; A=0x00, B=0xFF -> o_diff=0x01, o_borrow=1.
- i_start held high continuously with new operands presented in each DONE cycle -> results every 9 cycles; BUSY-cycle start and operand changes ignored; each o_done is exactly 1 cycle.
- Assert i_reset during BUSY cycle 4 -> next cycle state IDLE, all outputs 0, no o_done; a subsequent start with A=0x10, B=0x01 yields o_diff=0x0F.
- Randomised sweep, 1000 operand pairs for N=8 and N=16, compared against a reference model -> o_diff, o_borrow, o_zero and o_overflow all match.
